tcam_lookup_scheduler: RTL and testbench
========================================

TCAM_LOOKUP_SCHEDULER -- requirements
Module: tcam_lookup_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of lookup requesters.
REQ-002 The block SHALL have parameter ID_W, default 4, giving the packet/destination ID width.
REQ-003 The block SHALL have parameters BITS (default 8), ADDR_W (default 4) and LOOKUP_LAT (default 3, minimum 3), where LOOKUP_LAT is the number of cycles from lookup issue to mem_dst valid.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester lookup request.
REQ-007 The block SHALL have port req_id, input, NREQ*ID_W bits: per-requester packet ID; requester k occupies slice [k*ID_W +: ID_W].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-hot lookup accept.
REQ-009 The block SHALL have port rsp_valid, output, NREQ bits: one-hot response strobe.
REQ-010 The block SHALL have port rsp_dst, output, ID_W bits: the looked-up destination ID, 0 on a miss.
REQ-011 The block SHALL have cfg_valid (in, 1), cfg_flush (in, 1), cfg_addr (in, ADDR_W), cfg_data (in, BITS), cfg_mask (in, BITS) and cfg_ready (out, 1) as the configuration port.
REQ-012 The block SHALL drive the memory side through mem_cs, mem_wr, mem_flush and mem_vbi (out, 1 bit each), mem_packet_id (out, ID_W), mem_data (out, BITS), mem_mask (out, BITS) and mem_addr (out, ADDR_W), and SHALL receive mem_dst (in, ID_W).
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, FLUSH, WRITE, LOOKUP and RESP; all outputs SHALL be registered.
REQ-015 In IDLE with cfg_valid=1, the block SHALL assert cfg_ready for exactly 1 cycle; the transfer completes on cfg_valid&cfg_ready, and the next state is FLUSH if cfg_flush=1, else WRITE.
REQ-016 FLUSH SHALL last 1 cycle with mem_cs=1, mem_flush=1 and mem_wr=0, then return to IDLE.
REQ-017 WRITE SHALL last 1 cycle with mem_cs=1, mem_wr=1, mem_vbi=1, and mem_addr, mem_data and mem_mask holding the captured cfg values; it then returns to IDLE.
REQ-018 In IDLE with no config selected and any req_valid set, the block SHALL grant the first set bit at or after rr_ptr (round-robin, wrapping NREQ-1 to 0), pulse req_ready for that bit for 1 cycle, capture that requester's ID, and enter LOOKUP.
REQ-019 LOOKUP SHALL hold mem_cs=1, mem_wr=0, mem_flush=0 and mem_packet_id=captured ID stable for exactly LOOKUP_LAT cycles, and SHALL then sample mem_dst into rsp_dst.
REQ-020 RESP SHALL last 1 cycle with mem_cs=0 and rsp_valid one-hot at the granted index; rsp_dst SHALL hold its value until the next RESP.
REQ-021 On leaving RESP, rr_ptr SHALL become (granted+1) mod NREQ, and the FSM SHALL go to IDLE.
REQ-022 Config SHALL have priority over lookups, except when the previous completed operation was a config and a req_valid is pending; in that case a lookup SHALL be served first (strict alternation, no starvation).
REQ-023 Only one operation SHALL be in flight at a time; req_ready and cfg_ready SHALL be 0 outside IDLE.
REQ-024 When the block is not in WRITE, mem_data and mem_mask SHALL be 0 and mem_addr SHALL be 0.
REQ-025 Deasserting req_valid after acceptance SHALL have no effect on the in-flight lookup.
REQ-026 req_valid bits that are not granted SHALL be held off with no loss of pending state, since the requester holds req_valid.

Reset
REQ-027 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE, rr_ptr and last-op-was-config SHALL become 0, and all outputs SHALL become 0 (rsp_dst included).
REQ-028 A reset during LOOKUP or WRITE SHALL abort the operation; no rsp_valid SHALL be produced afterwards for that operation.

Verification
REQ-029 Reset, then cfg write addr=3, data=0x5A, mask=0xF0 -> one cycle with mem_cs=1, mem_wr=1, mem_addr=3, mem_data=0x5A, mem_mask=0xF0; busy=1 for 1 cycle.
REQ-030 Requester 2 issues id=0x5 and the model returns mem_dst=0xA -> req_ready=0b0100 one cycle; mem_cs high 3 cycles with mem_packet_id=0x5; rsp_valid=0b0100 with rsp_dst=0xA on cycle 5 after acceptance; rr_ptr=3.
REQ-031 All four requesters are held valid from reset -> grant order 0,1,2,3,0; each lookup takes 5 cycles including grant.
REQ-032 cfg_valid and req_valid[1] are held continuously -> operations alternate config, lookup, config, lookup.
REQ-033 rst_n=0 in the 2nd LOOKUP cycle -> mem_cs=0 the next cycle, no rsp_valid ever produced, and the next grant goes to requester 0.
REQ-034 cfg_flush=1 -> one cycle with mem_cs=1, mem_flush=1 and mem_wr=0; a subsequent lookup returns rsp_dst=0 (miss).

Source files
------------

// File: rtl/tcam_lookup_scheduler.sv
// Arbitrates NREQ lookup requesters and a configuration port onto one TCAM memory port.
// One operation in flight at a time; every output is registered from the next state.
module tcam_lookup_scheduler #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 4,
  parameter int BITS       = 8,
  parameter int ADDR_W     = 4,
  parameter int LOOKUP_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ID_W-1:0]   req_id,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [ID_W-1:0]        rsp_dst,
  input  logic                   cfg_valid,
  input  logic                   cfg_flush,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [BITS-1:0]        cfg_data,
  input  logic [BITS-1:0]        cfg_mask,
  output logic                   cfg_ready,
  output logic                   mem_cs,
  output logic                   mem_wr,
  output logic                   mem_flush,
  output logic                   mem_vbi,
  output logic [ID_W-1:0]        mem_packet_id,
  output logic [BITS-1:0]        mem_data,
  output logic [BITS-1:0]        mem_mask,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [ID_W-1:0]        mem_dst,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LOOKUP_LAT + 1);

  typedef enum logic [2:0] {IDLE, FLUSH, WRITE, LOOKUP, RESP} state_t;

  state_t            state, state_n;
  logic [PTR_W-1:0]  rr_ptr, rr_n, gnt_idx, gnt_n, pick_idx;
  logic              last_cfg, last_n, pick_found, cfg_ready_d;
  logic [ID_W-1:0]   id_q, id_n, dst_n;
  logic [CNT_W-1:0]  lat_cnt, cnt_n;
  logic [NREQ-1:0]   req_ready_d, rsp_valid_d;

  // First set bit at or after p, wrapping; scanning downwards lets the nearest one win.
  function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [PTR_W-1:0] p);
    logic [PTR_W:0] r;
    int j;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(p) + i) % NREQ;
      if (v[j]) r = {1'b1, j[PTR_W-1:0]};
    end
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    rr_n        = rr_ptr;
    last_n      = last_cfg;
    gnt_n       = gnt_idx;
    id_n        = id_q;
    cnt_n       = lat_cnt;
    dst_n       = rsp_dst;
    cfg_ready_d = 1'b0;
    req_ready_d = '0;
    rsp_valid_d = '0;

    case (state)
      IDLE: begin
        if (cfg_ready && cfg_valid) begin
          state_n = cfg_flush ? FLUSH : WRITE;
          last_n  = 1'b1;
        end else if (|(req_valid & req_ready)) begin
          state_n = LOOKUP;
          id_n    = req_id[gnt_idx*ID_W +: ID_W];
          cnt_n   = '0;
        end
      end
      FLUSH, WRITE: state_n = IDLE;
      LOOKUP: begin
        cnt_n = lat_cnt + 1'b1;
        if (lat_cnt == CNT_W'(LOOKUP_LAT - 1)) begin
          state_n = RESP;
          dst_n   = mem_dst;
        end
      end
      RESP: begin
        state_n = IDLE;
        rr_n    = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        last_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // The choice for the next IDLE cycle is made here so that its ready strobe is registered.
    {pick_found, pick_idx} = rr_pick(req_valid, rr_n);
    if (state_n == IDLE) begin
      if (cfg_valid && !(last_n && (|req_valid))) begin
        cfg_ready_d = 1'b1;
      end else if (pick_found) begin
        req_ready_d[pick_idx] = 1'b1;
        gnt_n                 = pick_idx;
      end
    end

    if (state_n == RESP) rsp_valid_d[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      last_cfg      <= 1'b0;
      gnt_idx       <= '0;
      id_q          <= '0;
      lat_cnt       <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_dst       <= '0;
      cfg_ready     <= 1'b0;
      mem_cs        <= 1'b0;
      mem_wr        <= 1'b0;
      mem_flush     <= 1'b0;
      mem_vbi       <= 1'b0;
      mem_packet_id <= '0;
      mem_data      <= '0;
      mem_mask      <= '0;
      mem_addr      <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_n;
      last_cfg      <= last_n;
      gnt_idx       <= gnt_n;
      id_q          <= id_n;
      lat_cnt       <= cnt_n;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_dst       <= dst_n;
      cfg_ready     <= cfg_ready_d;
      mem_cs        <= (state_n == FLUSH) || (state_n == WRITE) || (state_n == LOOKUP);
      mem_wr        <= (state_n == WRITE);
      mem_flush     <= (state_n == FLUSH);
      mem_vbi       <= (state_n == WRITE);
      mem_packet_id <= (state_n == LOOKUP) ? id_n : '0;
      mem_data      <= (state_n == WRITE) ? cfg_data : '0;
      mem_mask      <= (state_n == WRITE) ? cfg_mask : '0;
      mem_addr      <= (state_n == WRITE) ? cfg_addr : '0;
      busy          <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_tcam_lookup_scheduler.sv
// Directed bench for tcam_lookup_scheduler with a delayed-response memory model
// and a response scoreboard filled at grant time and drained on rsp_valid.
module tb_tcam_lookup_scheduler;

  localparam int NREQ = 4, ID_W = 4, BITS = 8, ADDR_W = 4, LAT = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*ID_W-1:0] req_id;
  logic [NREQ-1:0]      req_ready, rsp_valid;
  logic [ID_W-1:0]      rsp_dst;
  logic                 cfg_valid, cfg_flush, cfg_ready;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [BITS-1:0]      cfg_data, cfg_mask;
  logic                 mem_cs, mem_wr, mem_flush, mem_vbi, busy;
  logic [ID_W-1:0]      mem_packet_id, mem_dst;
  logic [BITS-1:0]      mem_data, mem_mask;
  logic [ADDR_W-1:0]    mem_addr;

  typedef struct {
    int              idx;
    logic [ID_W-1:0] dst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   g, prev_g, kind;

  always #5 clk = ~clk;

  tcam_lookup_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .BITS(BITS), .ADDR_W(ADDR_W),
                          .LOOKUP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dst(rsp_dst),
    .cfg_valid(cfg_valid), .cfg_flush(cfg_flush), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_flush(mem_flush), .mem_vbi(mem_vbi),
    .mem_packet_id(mem_packet_id), .mem_data(mem_data), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_dst(mem_dst), .busy(busy)
  );

  // Memory model: destination is ~id (0 after a flush), valid only in the last lookup cycle.
  logic flushed = 1'b0;
  int   cs_cnt = 0;
  always @(posedge clk) begin
    cs_cnt <= mem_cs ? cs_cnt + 1 : 0;
    if (mem_cs && mem_flush) flushed <= 1'b1;
    else if (mem_cs && mem_wr) flushed <= 1'b0;
  end
  assign mem_dst = (cs_cnt == LAT - 1) ? (flushed ? '0 : (mem_packet_id ^ {ID_W{1'b1}}))
                                       : ID_W'(7);

  function automatic logic [ID_W-1:0] expDst(input logic [ID_W-1:0] id);
    return flushed ? '0 : (id ^ {ID_W{1'b1}});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step;
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyStimulus(input logic cv, input logic cf, input logic [ADDR_W-1:0] a,
                               input logic [BITS-1:0] d, input logic [BITS-1:0] m,
                               input logic [NREQ-1:0] rv);
    cfg_valid = cv;
    cfg_flush = cf;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_mask  = m;
    req_valid = rv;
  endtask

  task automatic waitGrant(input int exp_idx, output int gcyc);
    int n;
    n = 0;
    step;
    while (req_ready == '0 && n < 20) begin
      step;
      n++;
    end
    checkOutput("grant_wait_ok", 32'(n < 20), 1);
    checkOutput("grant_onehot", 32'(req_ready), 32'(1) << exp_idx);
    checkOutput("grant_cfg_ready_low", 32'(cfg_ready), 0);
    sb.push_back('{exp_idx, expDst(req_id[exp_idx*ID_W +: ID_W])});
    gcyc = cyc;
  endtask

  task automatic waitCfg;
    int n;
    n = 0;
    step;
    while (cfg_ready !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    checkOutput("cfg_wait_ok", 32'(n < 20), 1);
    checkOutput("cfg_req_ready_low", 32'(req_ready), 0);
    checkOutput("cfg_busy_low", 32'(busy), 0);
  endtask

  // kind: 1 = config accepted, 2 = lookup granted (requester 1 expected).
  task automatic waitOp(output int k);
    int n;
    n = 0;
    k = 0;
    step;
    while (cfg_ready !== 1'b1 && req_ready == '0 && n < 20) begin
      step;
      n++;
    end
    checkOutput("op_wait_ok", 32'(n < 20), 1);
    if (cfg_ready === 1'b1) k = 1;
    else if (req_ready != '0) begin
      k = 2;
      checkOutput("op_grant", 32'(req_ready), 32'h2);
      sb.push_back('{1, expDst(req_id[1*ID_W +: ID_W])});
    end
  endtask

  task automatic waitDrain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      step;
      n++;
    end
    checkOutput("sb_drain", 32'(sb.size()), 0);
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n === 1'b1 && rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        checkOutput("rsp_dst", 32'(rsp_dst), 32'(e.dst));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n  = 1'b0;
    req_id = {4'h3, 4'h5, 4'h6, 4'h1};
    applyStimulus(0, 0, '0, '0, '0, '0);
    repeat (3) step;

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_mem_cs", 32'(mem_cs), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_dst", 32'(rsp_dst), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 0);
    checkOutput("rst_mem_data", 32'(mem_data), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] config write");
    applyStimulus(1, 0, 4'd3, 8'h5A, 8'hF0, '0);
    waitCfg;
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    checkOutput("wr_mem_cs", 32'(mem_cs), 1);
    checkOutput("wr_mem_wr", 32'(mem_wr), 1);
    checkOutput("wr_mem_vbi", 32'(mem_vbi), 1);
    checkOutput("wr_mem_flush", 32'(mem_flush), 0);
    checkOutput("wr_mem_addr", 32'(mem_addr), 3);
    checkOutput("wr_mem_data", 32'(mem_data), 32'h5A);
    checkOutput("wr_mem_mask", 32'(mem_mask), 32'hF0);
    checkOutput("wr_busy", 32'(busy), 1);
    checkOutput("wr_cfg_ready", 32'(cfg_ready), 0);
    step;
    checkOutput("wr_end_mem_cs", 32'(mem_cs), 0);
    checkOutput("wr_end_busy", 32'(busy), 0);
    checkOutput("wr_end_mem_data", 32'(mem_data), 0);
    checkOutput("wr_end_mem_addr", 32'(mem_addr), 0);

    $display("[TB] single lookup from requester 2");
    applyStimulus(0, 0, '0, '0, '0, 4'b0100);
    waitGrant(2, g);
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("lk_mem_cs", 32'(mem_cs), 1);
      checkOutput("lk_mem_wr", 32'(mem_wr), 0);
      checkOutput("lk_packet_id", 32'(mem_packet_id), 32'h5);
      checkOutput("lk_req_ready", 32'(req_ready), 0);
      checkOutput("lk_mem_data", 32'(mem_data), 0);
      step;
    end
    checkOutput("lk_rsp_valid", 32'(rsp_valid), 32'b0100);
    checkOutput("lk_rsp_dst", 32'(rsp_dst), 32'hA);
    checkOutput("lk_rsp_mem_cs", 32'(mem_cs), 0);
    step;
    checkOutput("lk_rsp_once", 32'(rsp_valid), 0);
    checkOutput("lk_rsp_dst_hold", 32'(rsp_dst), 32'hA);
    waitDrain;

    $display("[TB] reset during lookup");
    applyStimulus(0, 0, '0, '0, '0, 4'b1001);
    waitGrant(3, g);
    step;
    step;
    rst_n = 1'b0;
    sb.delete();
    step;
    checkOutput("abort_mem_cs", 32'(mem_cs), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    waitGrant(0, g);
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    waitDrain;

    $display("[TB] all requesters held valid from reset");
    rst_n = 1'b0;
    applyStimulus(0, 0, '0, '0, '0, 4'b1111);
    step;
    step;
    rst_n  = 1'b1;
    prev_g = 0;
    for (int k = 0; k < 5; k++) begin
      waitGrant(k % NREQ, g);
      if (k > 0) checkOutput("grant_period", 32'(g - prev_g), 5);
      prev_g = g;
    end
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    waitDrain;

    $display("[TB] config and lookup alternation");
    applyStimulus(1, 0, 4'd1, 8'h11, 8'hFF, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      waitOp(kind);
      checkOutput("alt_kind", 32'(kind), (k % 2 == 0) ? 1 : 2);
    end
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    waitDrain;

    $display("[TB] flush then miss");
    applyStimulus(1, 1, '0, '0, '0, '0);
    waitCfg;
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    checkOutput("fl_mem_cs", 32'(mem_cs), 1);
    checkOutput("fl_mem_flush", 32'(mem_flush), 1);
    checkOutput("fl_mem_wr", 32'(mem_wr), 0);
    checkOutput("fl_mem_vbi", 32'(mem_vbi), 0);
    checkOutput("fl_busy", 32'(busy), 1);
    step;
    checkOutput("fl_end_mem_cs", 32'(mem_cs), 0);
    applyStimulus(0, 0, '0, '0, '0, 4'b0001);
    waitGrant(0, g);
    step;
    applyStimulus(0, 0, '0, '0, '0, '0);
    waitDrain;
    checkOutput("fl_miss_dst", 32'(rsp_dst), 0);

    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
